// File: rtl/rfetch_fwd_stage_pkg.sv
// Shared rvga types for the register-fetch slice: register index, data word,
// and the decode/rfetch control words.
package rfetch_fwd_stage_pkg;

  localparam int RVGA_NREGS = 32;
  localparam int RVGA_RW    = $clog2(RVGA_NREGS);
  localparam int RVGA_XW    = 32;

  typedef logic [RVGA_RW-1:0] rvga_reg;
  typedef logic [RVGA_XW-1:0] rvga_word;

  typedef struct packed {
    logic [7:0] op;
    rvga_reg    rs1;
    rvga_reg    rs2;
    rvga_reg    rd;
    logic       rd_w_v;
    logic       br_v;
    rvga_word   imm;
  } rvga_decode_cword;

  typedef struct packed {
    logic [7:0] op;
    rvga_reg    rs1;
    rvga_reg    rs2;
    rvga_reg    rd;
    logic       rd_w_v;
    logic       br_v;
    rvga_word   imm;
    rvga_word   rs1_data;
    rvga_word   rs2_data;
  } rvga_rfetch_cword;

  // x0 is hardwired, so a write to it never becomes a pending result.
  function automatic logic writes_reg(input rvga_decode_cword c);
    return c.rd_w_v && (c.rd != '0);
  endfunction

endpackage

// File: rtl/rfetch_fwd_stage_scoreboard.sv
// Per-register pending-write counters: +1 on issue, -1 on writeback and on a
// flushed writer, floored at 0 and capped at the counter maximum.
module rfetch_scoreboard
  import rfetch_fwd_stage_pkg::*;
#(
  parameter int NREGS_P = 32,
  parameter int CNT_W_P = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_v,
  input  rvga_reg            inc_rd,
  input  logic               wb_v,
  input  rvga_reg            wb_rd,
  input  logic               fl_v,
  input  rvga_reg            fl_rd,
  output logic [NREGS_P-1:0] busy,
  output logic [NREGS_P-1:0] sat
);

  localparam logic [CNT_W_P-1:0]        CNT_MAX   = '1;
  localparam logic signed [CNT_W_P+1:0] ONE_S     = 1;
  localparam logic signed [CNT_W_P+1:0] ZERO_S    = 0;
  localparam logic signed [CNT_W_P+1:0] CNT_MAX_S = signed'({2'b00, CNT_MAX});

  logic [CNT_W_P-1:0] cnt [NREGS_P];

  function automatic logic [CNT_W_P-1:0] cnt_step(input logic [CNT_W_P-1:0] c,
                                                  input logic inc, input logic dec_a,
                                                  input logic dec_b);
    logic signed [CNT_W_P+1:0] s;
    s = signed'({2'b00, c});
    if (inc)   s = s + ONE_S;
    if (dec_a) s = s - ONE_S;
    if (dec_b) s = s - ONE_S;
    if (s < ZERO_S)         return '0;
    else if (s > CNT_MAX_S) return CNT_MAX;
    else                    return s[CNT_W_P-1:0];
  endfunction

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS_P; r++) begin
      if (rst) cnt[r] <= '0;
      else     cnt[r] <= cnt_step(cnt[r],
                                  inc_v && (int'(inc_rd) == r),
                                  wb_v  && (int'(wb_rd)  == r),
                                  fl_v  && (int'(fl_rd)  == r));
    end
  end

  always_comb begin
    busy = '0;
    sat  = '0;
    for (int r = 0; r < NREGS_P; r++) begin
      busy[r] = (cnt[r] != '0);
      sat[r]  = (cnt[r] == CNT_MAX);
    end
  end

endmodule

// File: rtl/rfetch_fwd_stage.sv
// Register-fetch stage: register file, operand forwarding, RAW hazard stall and
// output register. Define RVGA_RF_WB_BYPASS_EN to bypass same-cycle writeback data.
module rfetch_fwd_stage
  import rfetch_fwd_stage_pkg::*;
#(
  parameter int WIDTH_P = 32,
  parameter int NREGS_P = 32,
  parameter int NFWD_P  = 2,
  parameter int CNT_W_P = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  rvga_decode_cword          cword_i,
  input  logic                      cword_v_i,
  output logic                      ready_o,
  input  logic                      stall_v_i,
  input  logic                      flush_v_i,
  output rvga_rfetch_cword          cword_o,
  output logic                      cword_v_o,
  output logic                      br_v_o,
  input  logic [NFWD_P-1:0]         fwd_v_i,
  input  logic [NFWD_P*RVGA_RW-1:0] fwd_rd_i,
  input  logic [NFWD_P*WIDTH_P-1:0] fwd_data_i,
  input  rvga_reg                   rd_i,
  input  logic [WIDTH_P-1:0]        rd_data_i,
  input  logic                      rd_w_v_i,
  output logic                      hazard_o
);

`ifdef RVGA_RF_WB_BYPASS_EN
  localparam bit WB_BYP = 1'b1;
`else
  localparam bit WB_BYP = 1'b0;
`endif

  typedef struct packed {
    logic               byp;
    logic [WIDTH_P-1:0] data;
  } opnd_t;

  logic [WIDTH_P-1:0] rf [NREGS_P];
  logic [NREGS_P-1:0] busy, sat;
  opnd_t              op1, op2;
  logic               issue, fl_dec;
  rvga_rfetch_cword   cword_p1;
  logic               vld_p1;

  // byp marks operands that do not depend on the register file, so they clear the hazard.
  function automatic opnd_t sel_opnd(input rvga_reg rs, input logic [WIDTH_P-1:0] rf_val);
    opnd_t o;
    o.byp  = 1'b0;
    o.data = rf_val;
    if (WB_BYP && rd_w_v_i && (rd_i == rs)) begin
      o.byp  = 1'b1;
      o.data = rd_data_i;
    end
    for (int k = NFWD_P - 1; k >= 0; k--) begin
      if (fwd_v_i[k] && (fwd_rd_i[k*RVGA_RW +: RVGA_RW] == rs)) begin
        o.byp  = 1'b1;
        o.data = fwd_data_i[k*WIDTH_P +: WIDTH_P];
      end
    end
    if (rs == '0) begin
      o.byp  = 1'b1;
      o.data = '0;
    end
    return o;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS_P; r++) rf[r] <= '0;
    end else if (rd_w_v_i && (rd_i != '0)) begin
      rf[rd_i] <= rd_data_i;
    end
  end

  always_comb begin
    op1      = sel_opnd(cword_i.rs1, rf[cword_i.rs1]);
    op2      = sel_opnd(cword_i.rs2, rf[cword_i.rs2]);
    hazard_o = cword_v_i && ((busy[cword_i.rs1] && !op1.byp) ||
                             (busy[cword_i.rs2] && !op2.byp) ||
                             (writes_reg(cword_i) && sat[cword_i.rd]));
  end

  assign ready_o = !hazard_o && !stall_v_i;
  assign issue   = cword_v_i && !hazard_o && !stall_v_i && !flush_v_i;
  assign fl_dec  = flush_v_i && vld_p1 && cword_p1.rd_w_v && (cword_p1.rd != '0);

  rfetch_scoreboard #(
    .NREGS_P (NREGS_P),
    .CNT_W_P (CNT_W_P)
  ) u_sb (
    .clk    (clk_i),
    .rst    (rst_i),
    .inc_v  (issue && writes_reg(cword_i)),
    .inc_rd (cword_i.rd),
    .wb_v   (rd_w_v_i && (rd_i != '0)),
    .wb_rd  (rd_i),
    .fl_v   (fl_dec),
    .fl_rd  (cword_p1.rd),
    .busy   (busy),
    .sat    (sat)
  );

  // Stage boundary: decode cword + operands -> rfetch output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      cword_p1 <= '0;
    end else if (flush_v_i) begin
      vld_p1   <= 1'b0;
    end else if (!stall_v_i) begin
      vld_p1   <= issue;
      if (issue) cword_p1 <= {cword_i, op1.data, op2.data};
    end
  end

  assign cword_o   = cword_p1;
  assign cword_v_o = vld_p1;
  assign br_v_o    = vld_p1 && cword_p1.br_v;

endmodule

// File: tb/tb_rfetch_fwd_stage.sv
// Scoreboard bench for rfetch_fwd_stage: expected operands are queued at issue
// and compared when the cword appears on the output register.
`timescale 1ns/1ps
module tb_rfetch_fwd_stage;
  import rfetch_fwd_stage_pkg::*;

  localparam int NFWD = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  rvga_decode_cword       cword_i;
  logic                   cword_v_i;
  logic                   ready_o;
  logic                   stall_v_i;
  logic                   flush_v_i;
  rvga_rfetch_cword       cword_o;
  logic                   cword_v_o;
  logic                   br_v_o;
  logic [NFWD-1:0]        fwd_v_i;
  logic [NFWD*RVGA_RW-1:0] fwd_rd_i;
  logic [NFWD*32-1:0]     fwd_data_i;
  rvga_reg                rd_i;
  rvga_word               rd_data_i;
  logic                   rd_w_v_i;
  logic                   hazard_o;

  rfetch_fwd_stage #(
    .WIDTH_P (32),
    .NREGS_P (32),
    .NFWD_P  (NFWD),
    .CNT_W_P (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cword_i    (cword_i),
    .cword_v_i  (cword_v_i),
    .ready_o    (ready_o),
    .stall_v_i  (stall_v_i),
    .flush_v_i  (flush_v_i),
    .cword_o    (cword_o),
    .cword_v_o  (cword_v_o),
    .br_v_o     (br_v_o),
    .fwd_v_i    (fwd_v_i),
    .fwd_rd_i   (fwd_rd_i),
    .fwd_data_i (fwd_data_i),
    .rd_i       (rd_i),
    .rd_data_i  (rd_data_i),
    .rd_w_v_i   (rd_w_v_i),
    .hazard_o   (hazard_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    rvga_word e1;
    rvga_word e2;
    rvga_reg  rd;
    logic     br;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic stall_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rvga_decode_cword mk(input int rs1, input int rs2, input int rd,
                                          input logic wv);
    rvga_decode_cword c;
    c.op     = 8'($urandom);
    c.rs1    = rvga_reg'(rs1);
    c.rs2    = rvga_reg'(rs2);
    c.rd     = rvga_reg'(rd);
    c.rd_w_v = wv;
    c.br_v   = 1'($urandom);
    c.imm    = $urandom;
    return c;
  endfunction

  // Held (stalled) outputs are checked directly, so only fresh captures are popped.
  always @(posedge clk) stall_q <= stall_v_i;

  always @(negedge clk) begin
    exp_t e;
    if (cword_v_o && !stall_q && !rst) begin
      chk("out_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rs1_data", 64'(cword_o.rs1_data), 64'(e.e1));
        chk("rs2_data", 64'(cword_o.rs2_data), 64'(e.e2));
        chk("out_rd",   64'(cword_o.rd),       64'(e.rd));
        chk("br_v_o",   64'(br_v_o),           64'(e.br));
      end
    end
  end

  task automatic send(input rvga_decode_cword cw, input rvga_word e1, input rvga_word e2,
                      input string tag);
    int n;
    @(negedge clk);
    cword_i   = cw;
    cword_v_i = 1'b1;
    #1;
    chk({tag, "_nohaz"}, 64'(hazard_o), 64'(0));
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(ready_o), 64'(1));
    if (ready_o) q.push_back('{e1, e2, cw.rd, cw.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0;
  endtask

  task automatic wb(input int r, input rvga_word d);
    @(negedge clk);
    rd_i      = rvga_reg'(r);
    rd_data_i = d;
    rd_w_v_i  = 1'b1;
    @(negedge clk);
    rd_w_v_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cword_i = '0; cword_v_i = 1'b0; stall_v_i = 1'b0; flush_v_i = 1'b0;
    fwd_v_i = '0; fwd_rd_i = '0; fwd_data_i = '0; rd_i = '0; rd_data_i = '0; rd_w_v_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld",  64'(cword_v_o),        64'(0));
    chk("rst_data", 64'(cword_o.rs1_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'(1));

    // Plain RF read after reset
    send(mk(5, 0, 0, 1'b0), 32'h0, 32'h0, "t1");
    chk("t1_latency", 64'(cword_v_o), 64'(1));

    // Writeback then read, and read in the writeback cycle of a pending writer
    wb(3, 32'hA5A5);
    send(mk(3, 0, 0, 1'b0), 32'hA5A5, 32'h0, "t2rd");
    send(mk(0, 0, 3, 1'b1), 32'h0, 32'h0, "t2w");
    @(negedge clk);
    cword_i = mk(3, 0, 0, 1'b0); cword_v_i = 1'b1;
    rd_i = 5'd3; rd_data_i = 32'h5A5A; rd_w_v_i = 1'b1;
    #1;
`ifdef RVGA_RF_WB_BYPASS_EN
    chk("t2_wb_haz", 64'(hazard_o), 64'(0));
    q.push_back('{32'h5A5A, 32'h0, cword_i.rd, cword_i.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0; rd_w_v_i = 1'b0;
`else
    chk("t2_wb_haz", 64'(hazard_o), 64'(1));
    @(negedge clk);
    rd_w_v_i = 1'b0;
    #1;
    chk("t2_wb_retry", 64'(hazard_o), 64'(0));
    q.push_back('{32'h5A5A, 32'h0, cword_i.rd, cword_i.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0;
`endif

    // Forwarding priority
    send(mk(0, 0, 7, 1'b1), 32'h0, 32'h0, "t3w");
    fwd_v_i = 2'b10; fwd_rd_i = {5'd7, 5'd0}; fwd_data_i = {32'h11, 32'h0};
    send(mk(7, 0, 0, 1'b0), 32'h11, 32'h0, "t3f1");
    fwd_v_i = 2'b11; fwd_rd_i = {5'd7, 5'd7}; fwd_data_i = {32'h11, 32'h22};
    send(mk(7, 7, 0, 1'b0), 32'h22, 32'h22, "t3f0");
    fwd_v_i = 2'b00;
    wb(7, 32'h77);

    // Unresolved hazard, bubble, release by writeback
    send(mk(0, 0, 9, 1'b1), 32'h0, 32'h0, "t4w");
    @(negedge clk);
    cword_i = mk(9, 9, 0, 1'b0); cword_v_i = 1'b1;
    #1;
    chk("t4_haz",   64'(hazard_o), 64'(1));
    chk("t4_ready", 64'(ready_o),  64'(0));
    @(negedge clk);
    chk("t4_bubble", 64'(cword_v_o), 64'(0));
    chk("t4_haz2",   64'(hazard_o),  64'(1));
    cword_v_i = 1'b0; rd_i = 5'd9; rd_data_i = 32'h99; rd_w_v_i = 1'b1;
    @(negedge clk);
    rd_w_v_i = 1'b0; cword_v_i = 1'b1;
    #1;
    chk("t4_release", 64'(hazard_o), 64'(0));
    q.push_back('{32'h99, 32'h99, cword_i.rd, cword_i.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0;

    // Flush of a valid writer returns its count
    send(mk(0, 0, 4, 1'b1), 32'h0, 32'h0, "t5w");
    @(negedge clk);
    flush_v_i = 1'b1;
    @(negedge clk);
    flush_v_i = 1'b0;
    chk("t5_flush", 64'(cword_v_o), 64'(0));
    send(mk(4, 0, 0, 1'b0), 32'h0, 32'h0, "t5r");

    // Stall holds the output register
    send(mk(3, 7, 0, 1'b0), 32'h5A5A, 32'h77, "t7");
    stall_v_i = 1'b1; cword_i = mk(9, 0, 0, 1'b0); cword_v_i = 1'b1;
    #1;
    chk("t7_ready_stall", 64'(ready_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    chk("t7_hold_vld",  64'(cword_v_o),        64'(1));
    chk("t7_hold_data", 64'(cword_o.rs1_data), 64'(32'h5A5A));
    stall_v_i = 1'b0;
    #1;
    chk("t7_ready_go", 64'(ready_o), 64'(1));
    q.push_back('{32'h99, 32'h0, cword_i.rd, cword_i.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0;

    // Counter saturation and x0 reads
    for (int i = 0; i < 3; i++) send(mk(0, 0, 2, 1'b1), 32'h0, 32'h0, "t6w");
    wb(0, 32'hFFFF_FFFF);
    fwd_v_i = 2'b01; fwd_rd_i = {5'd0, 5'd0}; fwd_data_i = {32'h0, 32'hDEAD};
    send(mk(0, 0, 0, 1'b0), 32'h0, 32'h0, "t6x0");
    fwd_v_i = 2'b00;
    @(negedge clk);
    cword_i = mk(0, 0, 2, 1'b1); cword_v_i = 1'b1;
    #1;
    chk("t6_sat_haz",   64'(hazard_o), 64'(1));
    chk("t6_sat_ready", 64'(ready_o),  64'(0));
    @(negedge clk);
    rd_i = 5'd2; rd_data_i = 32'h22; rd_w_v_i = 1'b1;
    #1;
    chk("t6_sat_wb_haz", 64'(hazard_o), 64'(1));
    @(negedge clk);
    rd_w_v_i = 1'b0;
    #1;
    chk("t6_release", 64'(hazard_o), 64'(0));
    q.push_back('{32'h0, 32'h0, cword_i.rd, cword_i.br_v});
    @(posedge clk);
    #1;
    cword_v_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
